// File: rtl/mc_pkg.sv
// Shared types and defaults for the Monte-Carlo pipeline stages
// (comparator wrapper, hit counter, pi/area estimator).
package mc_pkg;

  localparam int MC_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mc_cnt_state_e;

endpackage

// File: rtl/mc_hit_counter.sv
// Counts samples and hits over a programmed run of N compare bits, then pulses done.
// Optional MC_HIT_COUNTER_STALL_CNT_EN adds a saturating count of RUN cycles without a valid sample.
module mc_hit_counter
  import mc_pkg::*;
#(
  parameter int CNT_WIDTH      = MC_CNT_WIDTH,
  parameter bit HIT_ON_GREATER = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_samples,
  input  logic                 sample_valid,
  input  logic                 cmp_bit,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic [CNT_WIDTH-1:0] hit_count
`ifdef MC_HIT_COUNTER_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_count
`endif
);

  mc_cnt_state_e        r_state;
  mc_cnt_state_e        w_state_nxt;
  logic [CNT_WIDTH-1:0] r_target;
  logic [CNT_WIDTH-1:0] r_sample_cnt;
  logic [CNT_WIDTH-1:0] r_hit_cnt;
  logic [CNT_WIDTH-1:0] w_sample_inc;
  logic                 w_accept;
  logic                 w_take;
  logic                 w_hit;
  logic                 w_last;

  assign w_accept     = (r_state == IDLE) && start;
  assign w_take       = (r_state == RUN) && sample_valid;
  assign w_hit        = (cmp_bit == HIT_ON_GREATER);
  assign w_sample_inc = r_sample_cnt + CNT_WIDTH'(1);
  // target is never zero in RUN, so the incremented count cannot wrap before matching
  assign w_last       = w_take && (w_sample_inc == r_target);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_target     <= '0;
      r_sample_cnt <= '0;
      r_hit_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_target     <= num_samples;
        r_sample_cnt <= '0;
        r_hit_cnt    <= '0;
      end else if (w_take) begin
        r_sample_cnt <= w_sample_inc;
        if (w_hit) begin
          r_hit_cnt <= r_hit_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

`ifdef MC_HIT_COUNTER_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_accept) begin
      r_stall_cnt <= '0;
    end else if ((r_state == RUN) && !sample_valid && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
    end
  end

  assign stall_count = r_stall_cnt;
`endif

  assign busy         = (r_state == RUN);
  assign done         = (r_state == DONE);
  assign sample_count = r_sample_cnt;
  assign hit_count    = r_hit_cnt;

endmodule

// File: tb/tb_mc_hit_counter.sv
// Directed bench for mc_hit_counter: run-level reference model checked every cycle,
// plus literal expectations at key points. Honours MC_HIT_COUNTER_STALL_CNT_EN.
module tb_mc_hit_counter;

  localparam int CW  = 16;
  localparam bit HOG = 1'b0;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_samples;
  logic          sample_valid;
  logic          cmp_bit;
  logic          busy;
  logic          done;
  logic [CW-1:0] sample_count;
  logic [CW-1:0] hit_count;
`ifdef MC_HIT_COUNTER_STALL_CNT_EN
  logic [CW-1:0] stall_count;
`endif

  mc_hit_counter #(
    .CNT_WIDTH     (CW),
    .HIT_ON_GREATER(HOG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .sample_valid(sample_valid),
    .cmp_bit     (cmp_bit),
    .busy        (busy),
    .done        (done),
    .sample_count(sample_count),
    .hit_count   (hit_count)
`ifdef MC_HIT_COUNTER_STALL_CNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endfunction

  // Run-level model: a run is "in flight" while samples remain outstanding;
  // the done flag marks the single reporting cycle that follows completion.
  bit m_in_flight;
  bit m_report;
  int m_left;
  int m_samples;
  int m_hits;
  int m_stalls;

  always @(posedge clk) begin
    if (rst) begin
      m_in_flight <= 1'b0;
      m_report    <= 1'b0;
      m_left      <= 0;
      m_samples   <= 0;
      m_hits      <= 0;
      m_stalls    <= 0;
    end else if (m_report) begin
      m_report <= 1'b0;
    end else if (m_in_flight) begin
      if (sample_valid) begin
        m_samples <= m_samples + 1;
        m_hits    <= m_hits + ((cmp_bit == HOG) ? 1 : 0);
        m_left    <= m_left - 1;
        if (m_left == 1) begin
          m_in_flight <= 1'b0;
          m_report    <= 1'b1;
        end
      end else begin
        m_stalls <= (m_stalls == MAXC) ? MAXC : m_stalls + 1;
      end
    end else if (start) begin
      m_samples <= 0;
      m_hits    <= 0;
      m_stalls  <= 0;
      m_left    <= int'(num_samples);
      if (num_samples == '0) m_report <= 1'b1;
      else                   m_in_flight <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), int'(m_in_flight));
      chk("done", int'(done), int'(m_report));
      chk("sample_count", int'(sample_count), m_samples);
      chk("hit_count", int'(hit_count), m_hits);
`ifdef MC_HIT_COUNTER_STALL_CNT_EN
      chk("stall_count", int'(stall_count), m_stalls);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input int n);
    start       = 1'b1;
    num_samples = CW'(n);
    step();
    start       = 1'b0;
  endtask

  task automatic sample(input bit v, input bit c);
    sample_valid = v;
    cmp_bit      = c;
    step();
    sample_valid = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    num_samples  = '0;
    sample_valid = 1'b0;
    cmp_bit      = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_samples", int'(sample_count), 0);
    step();

    // N=4, back-to-back samples, compare bits 0,1,0,0 -> 3 hits
    run_start(4);
    chk("t1_busy_after_start", int'(busy), 1);
    sample(1, 0);
    sample(1, 1);
    sample(1, 0);
    sample(1, 0);
    chk("t1_done", int'(done), 1);
    chk("t1_samples", int'(sample_count), 4);
    chk("t1_hits", int'(hit_count), 3);
    step();
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_hold_hits", int'(hit_count), 3);

    // N=3 with gaps; all compare bits 1 -> no hits; later valids ignored
    run_start(3);
    sample(1, 1);
    sample(0, 0);
    sample(0, 0);
    sample(1, 1);
    sample(0, 0);
    sample(0, 0);
    sample(1, 1);
    chk("t2_done", int'(done), 1);
    chk("t2_samples", int'(sample_count), 3);
    chk("t2_hits", int'(hit_count), 0);
    for (int i = 0; i < 3; i++) sample(1, 0);
    chk("t2_post_samples", int'(sample_count), 3);
    chk("t2_post_hits", int'(hit_count), 0);

    // N=0 goes straight to the done cycle
    run_start(0);
    chk("t3_done", int'(done), 1);
    chk("t3_busy", int'(busy), 0);
    chk("t3_samples", int'(sample_count), 0);
    step();
    chk("t3_done_gone", int'(done), 0);

    // Reset in the middle of an N=10 run aborts it without done
    run_start(10);
    for (int i = 0; i < 5; i++) sample(1, 0);
    chk("t4_mid_samples", int'(sample_count), 5);
    rst          = 1'b1;
    sample_valid = 1'b1;
    step();
    rst          = 1'b0;
    sample_valid = 1'b0;
    chk("t4_rst_busy", int'(busy), 0);
    chk("t4_rst_done", int'(done), 0);
    chk("t4_rst_samples", int'(sample_count), 0);
    step();
    chk("t4_no_done", int'(done), 0);
    run_start(2);
    sample(1, 1);
    sample(1, 0);
    chk("t4_new_done", int'(done), 1);
    chk("t4_new_samples", int'(sample_count), 2);
    step();

    // start held high with changing N during RUN is ignored
    run_start(6);
    for (int i = 0; i < 6; i++) begin
      start        = 1'b1;
      num_samples  = CW'($urandom_range(1, 50));
      sample_valid = 1'b1;
      cmp_bit      = (i % 2) == 1;
      step();
    end
    sample_valid = 1'b0;
    num_samples  = CW'(1);
    chk("t5_done", int'(done), 1);
    chk("t5_samples", int'(sample_count), 6);
    chk("t5_hits", int'(hit_count), 3);
    step();
    chk("t5_idle_busy", int'(busy), 0);
    step();
    start = 1'b0;
    chk("t5_restart_busy", int'(busy), 1);
    chk("t5_restart_clear", int'(sample_count), 0);
    sample(1, 0);
    chk("t5_restart_done", int'(done), 1);
    chk("t5_restart_hits", int'(hit_count), 1);
    step();

    // N=2 with valids three cycles apart: three stalled RUN cycles
    run_start(2);
    sample(1, 0);
    sample(0, 0);
    sample(0, 0);
    sample(0, 0);
    sample(1, 1);
    chk("t6_done", int'(done), 1);
    chk("t6_samples", int'(sample_count), 2);
    chk("t6_hits", int'(hit_count), 1);
`ifdef MC_HIT_COUNTER_STALL_CNT_EN
    chk("t6_stalls", int'(stall_count), 3);
    step();
    chk("t6_stalls_held", int'(stall_count), 3);
`else
    step();
`endif
    step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
